serial_div_large: RTL and testbench
===================================

// Module: serial_div_large
// PURPOSE
//  Sequential large-number divider: inverse operation of the team's 1024x1024 parallel multiplier.
//  Radix-2 restoring shift-subtract, one quotient bit per clock.
//  Divides a DIVIDEND_W-bit product (e.g. a 2048-bit multiplier result) by a DIVISOR_W-bit operand.
//  Start/done handshake; sits beside the multiplier in the large-arithmetic datapath.
// PARAMETERS
//  DIVIDEND_W  2048  dividend and quotient width
//  DIVISOR_W   1024  divisor and remainder width
//  CNT_W       12    iteration counter width; must satisfy 2**CNT_W > DIVIDEND_W
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous reset, active-high
//  start      in   1            request; sampled only in IDLE
//  dividend   in   DIVIDEND_W   sampled on the accepted start cycle only
//  divisor    in   DIVISOR_W    sampled on the accepted start cycle only
//  busy       out  1            high in RUN and DONE states
//  done       out  1            one-cycle pulse; results valid from this cycle on
//  dbz        out  1            divide-by-zero flag; valid with done
//  quotient   out  DIVIDEND_W   result, held until the next accepted start
//  remainder  out  DIVISOR_W    result, held until the next accepted start
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state goes to IDLE; busy, done, dbz, quotient, remainder all go to 0.
//    Reset mid-RUN aborts the division; no done pulse follows.
//  - States: IDLE, RUN, DONE.
//  - IDLE & start & divisor!=0 -> RUN.
//    Latch dividend into shift reg Q and divisor into D; partial remainder R (DIVISOR_W+1 bits) := 0; cnt := DIVIDEND_W-1.
//  - IDLE & start & divisor==0 -> DONE.
//    quotient := all ones; remainder := dividend[DIVISOR_W-1:0]; dbz := 1.
//  - RUN, each cycle:
//    T = {R[DIVISOR_W-1:0], Q[MSB]}.
//    If T >= D then R := T-D and shift 1 into Q LSB; else R := T and shift 0 into Q LSB.
//    cnt := cnt-1. When cnt==0 this cycle, the next state is DONE.
//  - RUN lasts exactly DIVIDEND_W cycles. At the RUN->DONE transition: quotient := Q, remainder := R[DIVISOR_W-1:0], dbz := 0.
//  - DONE: done=1 for one cycle; next state is IDLE unconditionally.
//  - Latency: start accepted at edge k -> done high in cycle k+DIVIDEND_W+1.
//    Divide-by-zero: done high in cycle k+1.
//  - start while busy is ignored: no queueing, no effect on the operation in flight.
//    start in the same cycle as done is also ignored; the next start is accepted the cycle after done.
//  - rst and start in the same cycle: rst wins.
//  - R never exceeds DIVISOR_W+1 bits; the invariant R < D holds after every step.
//  - Widths: the subtract is done in DIVISOR_W+1 bits; the comparison uses the carry-out of T-D (no separate comparator).
// STRUCTURE
//  - Shared package/header: state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2), default widths.
//  - Sub-module div_step: combinational, one restoring step.
//    Inputs R, next dividend bit, D. Outputs next R and the quotient bit.
//  - Parent holds the FSM, the counter, the Q/R/D registers and the result registers.
// TESTING
//  Run every scenario at DIVIDEND_W=16/DIVISOR_W=8 and again at the defaults (random operands checked against a $-arith model).
//  1. 16/8: dividend 16'd1000, divisor 8'd7 -> quotient 142, remainder 6, dbz 0; done exactly 17 cycles after start.
//  2. 16/8: dividend 16'hFFFF, divisor 8'd1 -> quotient 16'hFFFF, remainder 0.
//     dividend 16'd5, divisor 8'd200 -> quotient 0, remainder 5.
//  3. 16/8: divisor 0, dividend 16'h1234 -> done next cycle; dbz 1; quotient 16'hFFFF; remainder 8'h34.
//  4. 16/8: start pulsed again mid-RUN with new operands -> ignored; first result unchanged.
//     Back-to-back start the cycle after done -> accepted.
//  5. rst asserted 5 cycles into RUN -> all outputs 0, no done.
//     Following start of 100/3 -> quotient 33, remainder 1.
//  6. Default widths: dividend = (2^1024-1)^2, divisor 2^1024-1 -> quotient 2^1024-1, remainder 0; done at 2049 cycles.

Source files
------------

// File: rtl/serial_div_large_pkg.sv
// Shared types and default widths for the large-number serial divider.
package serial_div_large_pkg;

    localparam int DEF_DIVIDEND_W = 2048;
    localparam int DEF_DIVISOR_W  = 1024;
    localparam int DEF_CNT_W      = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_div_large_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
    import serial_div_large_pkg::*;
#(
    parameter int W = DEF_DIVISOR_W
) (
    input  logic [W:0]   i_r,
    input  logic         i_bit,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_r,
    output logic         o_q
);

    logic [W:0]   w_t;
    logic [W+1:0] w_diff;

    assign w_t    = {i_r[W-1:0], i_bit};
    assign w_diff = {1'b0, w_t} - {2'b00, i_d};
    // No borrow out of the subtract means T >= D.
    assign o_q    = ~w_diff[W+1];
    assign o_r    = o_q ? w_diff[W:0] : w_t;

    always_comb begin
        assert (i_r[W] == 1'b0);
    end

endmodule

// File: rtl/serial_div_large.sv
// Radix-2 restoring serial divider, one quotient bit per clock,
// with start/done handshake and divide-by-zero flag.
module serial_div_large
    import serial_div_large_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    state_t r_state;
    state_t w_next;

    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W:0]    r_r;
    logic [DIVISOR_W-1:0]  r_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_r_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_next;
    logic                  w_last;
    logic                  w_dz;

    div_step #(
        .W (DIVISOR_W)
    ) u_step (
        .i_r   (r_r),
        .i_bit (r_q[DIVIDEND_W-1]),
        .i_d   (r_d),
        .o_r   (w_r_next),
        .o_q   (w_qbit)
    );

    assign w_q_next = {r_q[DIVIDEND_W-2:0], w_qbit};
    assign w_last   = (r_cnt == '0);
    assign w_dz     = (divisor == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_dz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !w_dz) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= CNT_W'(DIVIDEND_W - 1);
                    end else if (start) begin
                        r_quot <= '1;
                        r_rem  <= dividend[DIVISOR_W-1:0];
                        r_dbz  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_r_next[DIVISOR_W-1:0];
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_serial_div_large.sv
// Scoreboard bench for serial_div_large at 16/8 and at default widths.
module tb_serial_div_large;

    localparam int SA = 16;
    localparam int SB = 8;
    localparam int LA = 2048;
    localparam int LB = 1024;

    typedef struct {
        logic [SA-1:0] q;
        logic [SB-1:0] r;
        logic          z;
    } s_exp_t;

    typedef struct {
        logic [LA-1:0] q;
        logic [LB-1:0] r;
        logic          z;
    } l_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          s_start = 1'b0;
    logic [SA-1:0] s_dividend = '0;
    logic [SB-1:0] s_divisor = '0;
    logic          s_busy, s_done, s_dbz;
    logic [SA-1:0] s_quot;
    logic [SB-1:0] s_rem;

    logic          l_start = 1'b0;
    logic [LA-1:0] l_dividend = '0;
    logic [LB-1:0] l_divisor = '0;
    logic          l_busy, l_done, l_dbz;
    logic [LA-1:0] l_quot;
    logic [LB-1:0] l_rem;

    s_exp_t s_sb[$];
    l_exp_t l_sb[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_div_large #(
        .DIVIDEND_W (SA),
        .DIVISOR_W  (SB),
        .CNT_W      (5)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .dividend  (s_dividend),
        .divisor   (s_divisor),
        .busy      (s_busy),
        .done      (s_done),
        .dbz       (s_dbz),
        .quotient  (s_quot),
        .remainder (s_rem)
    );

    serial_div_large u_large (
        .clk       (clk),
        .rst       (rst),
        .start     (l_start),
        .dividend  (l_dividend),
        .divisor   (l_divisor),
        .busy      (l_busy),
        .done      (l_done),
        .dbz       (l_dbz),
        .quotient  (l_quot),
        .remainder (l_rem)
    );

    task automatic check(input string tag, input logic [LA-1:0] act,
                         input logic [LA-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (low 64 bits)",
                     tag, act[63:0], exp[63:0]);
        end
    endtask

    always @(negedge clk) begin : s_mon
        s_exp_t e;
        if (s_done === 1'b1) begin
            if (s_sb.size() == 0) begin
                check("s_unexpected_done", 1, 0);
            end else begin
                e = s_sb.pop_front();
                check("s_quot", s_quot, e.q);
                check("s_rem", s_rem, e.r);
                check("s_dbz", s_dbz, e.z);
            end
        end
    end

    always @(negedge clk) begin : l_mon
        l_exp_t e;
        if (l_done === 1'b1) begin
            if (l_sb.size() == 0) begin
                check("l_unexpected_done", 1, 0);
            end else begin
                e = l_sb.pop_front();
                check("l_quot", l_quot, e.q);
                check("l_rem", l_rem, e.r);
                check("l_dbz", l_dbz, e.z);
            end
        end
    end

    function automatic s_exp_t s_model(input logic [SA-1:0] a,
                                       input logic [SB-1:0] b);
        s_exp_t        e;
        logic [SA-1:0] bx;
        logic [SA-1:0] rm;
        bx = {8'd0, b};
        if (b == '0) begin
            e.q = '1;
            e.r = a[SB-1:0];
            e.z = 1'b1;
        end else begin
            rm  = a % bx;
            e.q = a / bx;
            e.r = rm[SB-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic l_exp_t l_model(input logic [LA-1:0] a,
                                       input logic [LB-1:0] b);
        l_exp_t        e;
        logic [LA-1:0] bx;
        logic [LA-1:0] rm;
        bx = {{(LA-LB){1'b0}}, b};
        if (b == '0) begin
            e.q = '1;
            e.r = a[LB-1:0];
            e.z = 1'b1;
        end else begin
            rm  = a % bx;
            e.q = a / bx;
            e.r = rm[LB-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic s_run(input logic [SA-1:0] a, input logic [SB-1:0] b,
                         input int lat);
        int n;
        @(negedge clk);
        s_dividend = a;
        s_divisor  = b;
        s_start    = 1'b1;
        s_sb.push_back(s_model(a, b));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            s_start = 1'b0;
            n++;
        end while (s_done !== 1'b1 && n < lat + 20);
        check("s_latency", n, lat);
        @(negedge clk);
    endtask

    task automatic l_run(input logic [LA-1:0] a, input logic [LB-1:0] b,
                         input int lat);
        int n;
        @(negedge clk);
        l_dividend = a;
        l_divisor  = b;
        l_start    = 1'b1;
        l_sb.push_back(l_model(a, b));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            l_start = 1'b0;
            n++;
        end while (l_done !== 1'b1 && n < lat + 20);
        check("l_latency", n, lat);
        @(negedge clk);
    endtask

    initial begin : stim
        int            n;
        logic [LB-1:0] ones;
        logic [LA-1:0] big;
        logic [LB-1:0] dv;

        repeat (3) @(posedge clk);
        #1;
        check("s_rst_busy", s_busy, 0);
        check("s_rst_done", s_done, 0);
        check("s_rst_dbz", s_dbz, 0);
        check("s_rst_quot", s_quot, 0);
        check("s_rst_rem", s_rem, 0);
        check("l_rst_busy", l_busy, 0);
        check("l_rst_quot", l_quot, 0);
        @(negedge clk);
        rst = 1'b0;

        s_run(16'd1000, 8'd7, SA + 1);
        s_run(16'hFFFF, 8'd1, SA + 1);
        s_run(16'd5, 8'd200, SA + 1);
        s_run(16'h1234, 8'd0, 1);

        // Restart mid-run is ignored; restart during done takes one extra edge.
        @(negedge clk);
        s_dividend = 16'd1000;
        s_divisor  = 8'd7;
        s_start    = 1'b1;
        s_sb.push_back(s_model(16'd1000, 8'd7));
        @(posedge clk);
        #1;
        s_start = 1'b0;
        check("s_busy_run", s_busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        s_dividend = 16'hABCD;
        s_divisor  = 8'd3;
        s_start    = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        n = 0;
        while (s_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("s_mid_done_seen", s_done, 1);
        s_dividend = 16'd100;
        s_divisor  = 8'd3;
        s_start    = 1'b1;
        s_sb.push_back(s_model(16'd100, 8'd3));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) s_start = 1'b0;
        end while (s_done !== 1'b1 && n < 40);
        check("s_b2b_latency", n, SA + 2);
        @(negedge clk);

        // Reset partway through a run aborts it without a done pulse.
        @(negedge clk);
        s_dividend = 16'd200;
        s_divisor  = 8'd9;
        s_start    = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s_abort_busy", s_busy, 0);
        check("s_abort_done", s_done, 0);
        check("s_abort_dbz", s_dbz, 0);
        check("s_abort_quot", s_quot, 0);
        check("s_abort_rem", s_rem, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("s_abort_idle", s_busy, 0);
        s_run(16'd100, 8'd3, SA + 1);

        for (int i = 0; i < 6; i++) begin
            s_run(16'($urandom), 8'($urandom_range(1, 255)), SA + 1);
        end

        ones = '1;
        big  = {{LB{1'b0}}, ones} * {{LB{1'b0}}, ones};
        l_run(big, ones, LA + 1);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < LA / 32; j++) big[j*32 +: 32] = $urandom;
            dv = '0;
            if (k == 0) begin
                for (int j = 0; j < LB / 32; j++) dv[j*32 +: 32] = $urandom;
            end else begin
                dv[31:0] = $urandom;
            end
            if (dv == '0) dv = 1;
            l_run(big, dv, LA + 1);
        end
        l_run(big, '0, 1);

        repeat (5) @(negedge clk);
        check("s_sb_empty", s_sb.size(), 0);
        check("l_sb_empty", l_sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
